lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the execute stage and a variable-latency data-memory bus.
//  Sequences each load/store decoded by the controller (opcodes 0000011 / 0100011, size from funct3) into one bus transaction.
//  Generates byte enables and write-data lanes, and extracts plus sign/zero-extends load data.
//  Holds the pipeline via stall; raises misaligned, illegal-size and bus-timeout exceptions toward the CSR unit.
// PARAMETERS
//  TIMEOUT  255  max cycles spent in REQ+WAIT before bus-error abort; 0 disables the timeout
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous active-high reset
//  ls_valid     in   1   execute stage holds a load/store; held stable while stall=1
//  is_load      in   1   instruction is a load (wins if is_store also high)
//  is_store     in   1   instruction is a store
//  funct3       in   3   access size/sign (LB/LH/LW/LBU/LHU; SB/SH/SW)
//  addr         in   32  effective byte address (ALU result)
//  wdata        in   32  store data (rs2)
//  stall        out  1   freeze PC/pipeline registers
//  rdata        out  32  extended load result, valid when rdata_valid=1
//  rdata_valid  out  1   1-cycle pulse: load result ready, write back this cycle
//  exc          out  1   1-cycle exception pulse
//  exc_cause    out  2   01 misaligned, 10 bus timeout, 11 illegal funct3
//  exc_addr     out  32  faulting byte address
//  bus_req      out  1   bus request; held until bus_gnt sampled high
//  bus_we       out  1   1 = write
//  bus_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_gnt      in   1   request accepted this cycle
//  bus_rvalid   in   1   response: read data valid / write acknowledged
//  bus_rdata    in   32  read data
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all outputs 0; async, so bus_req drops immediately and any transaction in flight is abandoned.
//  States:
//   IDLE  stall = ls_valid & (is_load|is_store).
//         On a request, register addr, funct3, we=~is_load, be and wdata lanes.
//         Size/alignment check: illegal funct3 -> EXC(11); misaligned -> EXC(01); otherwise -> REQ.
//         Illegal funct3: load 011/110/111, store >=011. Misaligned: H with addr[0]!=0, W with addr[1:0]!=0.
//   REQ   bus_req=1, stall=1; bus_addr/we/be/wdata stable from registers.
//         On gnt&rvalid -> DONE; on gnt -> WAIT.
//   WAIT  stall=1; on rvalid -> DONE.
//         Stores also wait for rvalid, which acts as the write acknowledge.
//   DONE  stall=0; rdata_valid=1 for loads only; -> IDLE.
//         A new request is not sampled in DONE; the pipeline advances on this edge.
//   EXC   stall=0, exc=1, exc_cause/exc_addr from registers; no bus activity; -> IDLE.
//   Timeout: if TIMEOUT!=0, counter increments in REQ/WAIT and clears elsewhere.
//         Reaching TIMEOUT in REQ or WAIT -> EXC(10), bus_req drops; a late rvalid is ignored in IDLE.
//  Lanes:
//   SB: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
//   SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
//   SW: be = 1111.
//  Load extract (rdata captured on rvalid, shifted by registered addr[1:0]):
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  Latency: issue at T (stall=1), bus_req at T+1. Minimum DONE is T+2 (gnt&rvalid at T+1); stall totals 2 cycles minimum.
//  exc, rdata_valid and bus_req are mutually exclusive. rdata holds its value outside DONE. exc_* hold their value until the next exception.
// TESTING
//  LB addr=0x103, bus_rdata=0x80FF_FF00, gnt&rvalid same cycle -> bus_be=1000, rdata=0xFFFF_FF80, stall high exactly 2 cycles.
//  SH addr=0x202 wdata=0x1234_ABCD, gnt delayed 3 cycles, rvalid 2 later -> bus_req held 4 cycles, be=1100, bus_wdata=0xABCD_ABCD, no rdata_valid.
//  LW addr=0x101 -> exc=1 with exc_cause=01 and exc_addr=0x101 at T+1; bus_req never asserted; stall=1 only at T.
//  TIMEOUT=4, bus_gnt tied 0 -> exc_cause=10 after 4 REQ cycles; bus_req low next; later rvalid ignored.
//  Load funct3=011 -> exc_cause=11; store with is_load=is_store=1 -> treated as load (bus_we=0).
//  rst asserted while in WAIT -> bus_req/stall drop asynchronously; state IDLE; next LHU addr=0x2, rdata=0xBEEF_0000 -> rdata=0x0000_BEEF.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns one decoded load/store into a single data-bus transaction,
// generating byte lanes, extending load data and raising alignment/size/timeout exceptions.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_EXC  = 3'd4
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [CW-1:0] cnt_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   bus_wdata_q;
    logic [31:0]   rdata_q;
    logic          rdata_valid_q;
    logic          exc_q;
    logic [1:0]    exc_cause_q;
    logic [31:0]   exc_addr_q;

    logic          req_s;
    logic          illegal_s;
    logic          misalign_s;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic          timeout_s;
    logic [CW-1:0] cnt_d;

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  ofs,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {ofs, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h00_0000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Request decode, size/alignment checks and byte-lane generation from the live inputs.
    always_comb begin
        req_s      = ls_valid & (is_load | is_store);
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wdata;
        if (is_load) begin
            illegal_s = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end else begin
            illegal_s = funct3[2] || (funct3[1:0] == 2'b11);
        end
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign_s = addr[0];
                be_d       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{wdata[15:0]}};
            end
            2'b10: begin
                misalign_s = |addr[1:0];
            end
            default: begin
                misalign_s = 1'b0;
            end
        endcase
    end

    assign timeout_s = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST);
    assign cnt_d     = (TIMEOUT != 32'd0) ? cnt_q + CW'(1'b1) : cnt_q;

    // Stall is the only output that must react in the issue cycle; reset forces it low.
    assign stall = !rst && (((state_q == S_IDLE) && req_s) ||
                            (state_q == S_REQ) || (state_q == S_WAIT));

    // Transaction sequencer with registered bus, result and exception outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= 32'h0000_0000;
            funct3_q      <= 3'b000;
            cnt_q         <= {CW{1'b0}};
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0000_0000;
            bus_be_q      <= 4'b0000;
            bus_wdata_q   <= 32'h0000_0000;
            rdata_q       <= 32'h0000_0000;
            rdata_valid_q <= 1'b0;
            exc_q         <= 1'b0;
            exc_cause_q   <= 2'b00;
            exc_addr_q    <= 32'h0000_0000;
        end else begin
            rdata_valid_q <= 1'b0;
            exc_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= {CW{1'b0}};
                    if (req_s) begin
                        addr_q      <= addr;
                        funct3_q    <= funct3;
                        bus_we_q    <= !is_load;
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= be_d;
                        bus_wdata_q <= wdata_d;
                        if (illegal_s) begin
                            state_q     <= S_EXC;
                            exc_q       <= 1'b1;
                            exc_cause_q <= 2'b11;
                            exc_addr_q  <= addr;
                        end else if (misalign_s) begin
                            state_q     <= S_EXC;
                            exc_q       <= 1'b1;
                            exc_cause_q <= 2'b01;
                            exc_addr_q  <= addr;
                        end else begin
                            state_q   <= S_REQ;
                            bus_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_d;
                    if (bus_gnt && bus_rvalid) begin
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (!bus_we_q) begin
                            rdata_valid_q <= 1'b1;
                            rdata_q       <= load_extract(bus_rdata, addr_q[1:0], funct3_q);
                        end
                    end else if (timeout_s) begin
                        bus_req_q   <= 1'b0;
                        state_q     <= S_EXC;
                        exc_q       <= 1'b1;
                        exc_cause_q <= 2'b10;
                        exc_addr_q  <= addr_q;
                    end else if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // For stores rvalid is the write acknowledge.
                    if (bus_rvalid) begin
                        state_q <= S_DONE;
                        if (!bus_we_q) begin
                            rdata_valid_q <= 1'b1;
                            rdata_q       <= load_extract(bus_rdata, addr_q[1:0], funct3_q);
                        end
                    end else if (timeout_s) begin
                        state_q     <= S_EXC;
                        exc_q       <= 1'b1;
                        exc_cause_q <= 2'b10;
                        exc_addr_q  <= addr_q;
                    end
                end
                S_DONE, S_EXC: begin
                    cnt_q   <= {CW{1'b0}};
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q     <= {CW{1'b0}};
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign exc         = exc_q;
    assign exc_cause   = exc_cause_q;
    assign exc_addr    = exc_addr_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule
